// File: rtl/ttl_cen_gen_sync.sv
// Fractional clock-enable generator: produces a square-wave Cen at
// Clk * Num / (2 * Den) with exact long-term phase, plus registered
// single-cycle rise/fall strobes, a wrapping rise counter and a
// configuration error flag. All outputs come straight from flops.
module ttl_cen_gen_sync #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             Sync_n,
  input  logic [W-1:0]     Num,
  input  logic [W-1:0]     Den,
  output logic             Cen,
  output logic             Cen_rise,
  output logic             Cen_fall,
  output logic [CNT_W-1:0] Rise_cnt,
  output logic             Err
);

  // Clamp the increment to Den so at most one half-period event fires per Clk.
  function automatic logic [W-1:0] eff_inc(input logic [W-1:0] n, input logic [W-1:0] d);
    return (n > d) ? d : n;
  endfunction

  // Reduce an accumulated sum by one modulus; the result always fits in W bits
  // because the increment never exceeds Den.
  function automatic logic [W-1:0] wrap_sub(input logic [W:0] s, input logic [W-1:0] d);
    return W'(s - {1'b0, d});
  endfunction

  logic [W-1:0]     acc_q,  acc_d;
  logic             cen_q,  cen_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             err_q,  err_d;

  logic [W-1:0]     n_eff;
  logic [W:0]       sum;
  logic             half_ev;

  // Phase sum in W+1 bits and half-period event detection.
  always_comb begin
    n_eff   = eff_inc(Num, Den);
    sum     = {1'b0, acc_q} + {1'b0, n_eff};
    half_ev = (Den != '0) && (sum >= {1'b0, Den});
  end

  // Next-state: Sync_n realign beats Run, Run beats stepping; Err always tracks inputs.
  always_comb begin
    acc_d  = acc_q;
    cen_d  = cen_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    cnt_d  = cnt_q;
    err_d  = (Den == '0) || (Num > Den);
    if (!Sync_n) begin
      acc_d = '0;
      cen_d = 1'b0;
    end else if (Run && (Den != '0)) begin
      if (half_ev) begin
        acc_d  = wrap_sub(sum, Den);
        cen_d  = ~cen_q;
        rise_d = ~cen_q;
        fall_d = cen_q;
        if (!cen_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        acc_d = sum[W-1:0];
      end
    end
  end

  // State register with synchronous active-low reset dominating everything.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      acc_q  <= '0;
      cen_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cen_q  <= cen_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign Cen      = cen_q;
  assign Cen_rise = rise_q;
  assign Cen_fall = fall_q;
  assign Rise_cnt = cnt_q;
  assign Err      = err_q;

endmodule
